// File: rtl/bus_register_bank.sv
// General-purpose register bank on the driver side of the datapath bus.
// Captures BusMuxOut on one-hot Rin strobes, encodes Rout into the mux select and tracks multi-driver requests.
module bus_register_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_SRC  = 24,
    parameter int CNT_W    = 8
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic [DATA_W-1:0]            BusMuxOut,
    input  logic [NUM_REGS-1:0]          Rin,
    input  logic [NUM_SRC-1:0]           Rout,
    input  logic                         BAout,
    output logic [4:0]                   select_signal,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic                         bus_idle,
    output logic                         conflict,
    output logic [CNT_W-1:0]             conflict_count
);

    logic [DATA_W-1:0] regFile [NUM_REGS];
    logic              multiDrive;
    logic              countFull;

    // Broadcast loads are legal: every strobed register takes the same bus value.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (Rin[i]) begin
                    regFile[i] <= BusMuxOut;
                end
            end
        end
    end

    // Fixed priority: scanning downwards leaves the lowest set index as the winner.
    always_comb begin
        select_signal = 5'd31;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (Rout[k]) begin
                select_signal = 5'(k);
            end
        end
    end

    assign bus_idle   = (Rout == '0);
    // Clearing the lowest set bit leaves something behind only when two or more bits are set.
    assign multiDrive = |(Rout & (Rout - NUM_SRC'(1)));
    assign countFull  = &conflict_count;

    always_ff @(posedge clock) begin
        if (clear) begin
            conflict       <= 1'b0;
            conflict_count <= '0;
        end else if (multiDrive) begin
            conflict <= 1'b1;
            if (!countFull) begin
                conflict_count <= conflict_count + CNT_W'(1);
            end
        end
    end

    // R0 doubles as a base-address register and reads as zero under BAout; storage is untouched.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regFile[i];
        end
        if (BAout) begin
            reg_out[0 +: DATA_W] = '0;
        end
    end

endmodule

// File: tb/tb_bus_register_bank.sv
// Directed and randomized checks of bus_register_bank against an array/arithmetic reference model.
module tb_bus_register_bank;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int NUM_SRC  = 24;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                       clock;
    logic                       clear;
    logic [DATA_W-1:0]          BusMuxOut;
    logic [NUM_REGS-1:0]        Rin;
    logic [NUM_SRC-1:0]         Rout;
    logic                       BAout;
    logic [4:0]                 select_signal;
    logic [NUM_REGS*DATA_W-1:0] reg_out;
    logic                       bus_idle;
    logic                       conflict;
    logic [CNT_W-1:0]           conflict_count;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0] modelRegs [NUM_REGS];
    bit                modelConflict;
    int unsigned       modelCount;
    logic [DATA_W-1:0] exp_q[$];

    bus_register_bank #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .BusMuxOut     (BusMuxOut),
        .Rin           (Rin),
        .Rout          (Rout),
        .BAout         (BAout),
        .select_signal (select_signal),
        .reg_out       (reg_out),
        .bus_idle      (bus_idle),
        .conflict      (conflict),
        .conflict_count(conflict_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DATA_W-1:0] observed, input logic [DATA_W-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Lowest set bit isolated by two's complement, then its index via log2.
    function automatic logic [DATA_W-1:0] expectedSelect(input logic [NUM_SRC-1:0] req);
        logic [NUM_SRC-1:0] lowest;
        if (req == '0) return 32'd31;
        lowest = req & (~req + NUM_SRC'(1));
        return DATA_W'($clog2(lowest));
    endfunction

    // Advance one clock: model reacts to the inputs present at the edge.
    task automatic clockEdge();
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = '0;
            modelConflict = 0;
            modelCount    = 0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) if (Rin[i]) modelRegs[i] = BusMuxOut;
            if ($countones(Rout) > 1) begin
                modelConflict = 1;
                if (modelCount < CNT_MAX) modelCount++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // scoreboard: queue expected outputs, then pop against observed
    task automatic checkAll(input string phase);
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back((i == 0 && BAout) ? '0 : modelRegs[i]);
        exp_q.push_back(expectedSelect(Rout));
        exp_q.push_back(DATA_W'(Rout == '0));
        exp_q.push_back(DATA_W'(modelConflict));
        exp_q.push_back(DATA_W'(modelCount));
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("%s.R%0d", phase, i), reg_out[i*DATA_W +: DATA_W], exp_q.pop_front());
        check({phase, ".select"}, DATA_W'(select_signal), exp_q.pop_front());
        check({phase, ".bus_idle"}, DATA_W'(bus_idle), exp_q.pop_front());
        check({phase, ".conflict"}, DATA_W'(conflict), exp_q.pop_front());
        check({phase, ".count"}, DATA_W'(conflict_count), exp_q.pop_front());
    endtask

    // driver
    task automatic drive(input logic c, input logic [DATA_W-1:0] bus, input logic [NUM_REGS-1:0] rin,
                         input logic [NUM_SRC-1:0] rout, input logic ba);
        clear     = c;
        BusMuxOut = bus;
        Rin       = rin;
        Rout      = rout;
        BAout     = ba;
        #1;
    endtask

    initial begin
        int mode;
        logic [NUM_SRC-1:0] r;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 'x;
        modelConflict = 0;
        modelCount    = 0;

        // reset
        drive(1'b1, '0, '0, '0, 1'b0);
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("reset");

        // single load of R5
        drive(1'b0, 32'hDEADBEEF, 16'h0020, '0, 1'b0);
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("loadR5");

        // single source, then two sources
        drive(1'b0, '0, '0, 24'(1) << 21, 1'b0);
        checkAll("sel21");
        clockEdge();
        checkAll("sel21.post");
        drive(1'b0, '0, '0, (24'(1) << 3) | (24'(1) << 20), 1'b0);
        checkAll("sel3");
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("conflict1");

        // R0 under BAout, including a load while gated
        drive(1'b0, 32'h00000040, 16'h0001, '0, 1'b0);
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b1);
        checkAll("ba1");
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("ba0");
        drive(1'b0, 32'h00000077, 16'h0001, '0, 1'b1);
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b1);
        checkAll("baLoad1");
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("baLoad0");

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) r = '0;
            else if (mode == 1) r = 24'(1) << $urandom_range(0, NUM_SRC - 1);
            else r = NUM_SRC'($urandom);
            drive(($urandom_range(0, 19) == 0), $urandom,
                  ($urandom_range(0, 3) == 0) ? '0 : NUM_REGS'($urandom), r, 1'($urandom));
            checkAll("rand");
            clockEdge();
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("rand.end");

        // saturation and clear
        drive(1'b1, '0, '0, '0, 1'b0);
        clockEdge();
        drive(1'b0, '0, '0, 24'h000006, 1'b0);
        for (int n = 0; n < 300; n++) clockEdge();
        checkAll("saturate");
        drive(1'b1, '0, '0, 24'h000006, 1'b0);
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("clearCount");

        // clear beats load
        drive(1'b0, 32'hA5A5A5A5, 16'h0006, '0, 1'b0);
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("preload");
        drive(1'b1, 32'h12345678, 16'h0006, '0, 1'b0);
        clockEdge();
        drive(1'b0, '0, '0, '0, 1'b0);
        checkAll("clearWins");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
